// File: rtl/instr_encoder_if.sv
// Handshake and field bus between the program-loader front end (master) and instr_encoder (slave).
// Carries decoded fields in and encoded words with their imem addresses out.
interface instr_encoder_if #(
   parameter int ADDR_W = 32
);
   logic              clear_i;
   logic              valid_i;
   logic              ready_o;
   logic [4:0]        opcode_i;
   logic [4:0]        rd_i;
   logic [2:0]        f3_i;
   logic [4:0]        rs1_i;
   logic [4:0]        rs2_i;
   logic [6:0]        f7_i;
   logic [31:0]       imm_i;
   logic              valid_o;
   logic              ready_i;
   logic [31:0]       instruction_o;
   logic [ADDR_W-1:0] addr_o;
   logic              illegal_o;

   modport master (
      output clear_i, valid_i, opcode_i, rd_i, f3_i, rs1_i, rs2_i, f7_i, imm_i, ready_i,
      input  ready_o, valid_o, instruction_o, addr_o, illegal_o
   );

   modport slave (
      input  clear_i, valid_i, opcode_i, rd_i, f3_i, rs1_i, rs2_i, f7_i, imm_i, ready_i,
      output ready_o, valid_o, instruction_o, addr_o, illegal_o
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them through a 2-entry FIFO with addresses.
// Optional INSTR_ENCODER_IMM_CHECK_EN flags out-of-range immediates as illegal (word still truncated-encoded).
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   instr_encoder_if.slave   bus
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]       w_word;
   logic              w_badOpcode;
   logic              w_immBad;
   logic              w_entryIll;
   logic              w_accept;
   logic              w_pop;
   logic [31:0]       w_imm;

   logic [32:0]       r_mem [2];
   logic              r_wrPtr;
   logic              r_rdPtr;
   logic [1:0]        r_count;
   logic [ADDR_W-1:0] r_addr;

   assign w_imm    = bus.imm_i;
   assign w_accept = bus.valid_i && bus.ready_o;
   assign w_pop    = bus.valid_o && bus.ready_i;

   always_comb begin
      w_word      = NOP;
      w_badOpcode = 1'b0;
      case (bus.opcode_i)
         5'b01100:
            w_word = {bus.f7_i, bus.rs2_i, bus.rs1_i, bus.f3_i, bus.rd_i, bus.opcode_i, 2'b11};
         5'b00100, 5'b00000, 5'b11001, 5'b00011, 5'b11100:
            w_word = {w_imm[11:0], bus.rs1_i, bus.f3_i, bus.rd_i, bus.opcode_i, 2'b11};
         5'b01000:
            w_word = {w_imm[11:5], bus.rs2_i, bus.rs1_i, bus.f3_i, w_imm[4:0], bus.opcode_i, 2'b11};
         5'b11000:
            w_word = {w_imm[12], w_imm[10:5], bus.rs2_i, bus.rs1_i, bus.f3_i,
                      w_imm[4:1], w_imm[11], bus.opcode_i, 2'b11};
         5'b01101, 5'b00101:
            w_word = {w_imm[31:12], bus.rd_i, bus.opcode_i, 2'b11};
         5'b11011:
            w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd_i, bus.opcode_i, 2'b11};
         default: begin
            w_word      = NOP;
            w_badOpcode = 1'b1;
         end
      endcase
   end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   // Upper immediate bits must be a pure sign extension of the encodable field.
   always_comb begin
      w_immBad = 1'b0;
      case (bus.opcode_i)
         5'b00100, 5'b00000, 5'b11001, 5'b00011, 5'b11100, 5'b01000:
            w_immBad = !((&w_imm[31:11]) || !(|w_imm[31:11]));
         5'b11000:
            w_immBad = !((&w_imm[31:12]) || !(|w_imm[31:12])) || w_imm[0];
         5'b11011:
            w_immBad = !((&w_imm[31:20]) || !(|w_imm[31:20])) || w_imm[0];
         5'b01101, 5'b00101:
            w_immBad = |w_imm[11:0];
         default:
            w_immBad = 1'b0;
      endcase
   end
`else
   assign w_immBad = 1'b0;
`endif

   assign w_entryIll = w_badOpcode | w_immBad;

   // FIFO storage, pointers, occupancy and address counter; clear outranks accept and pop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
         r_addr   <= BASE_ADDR;
      end else if (bus.clear_i) begin
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
         r_addr   <= BASE_ADDR;
      end else begin
         if (w_accept) begin
            r_mem[r_wrPtr] <= {w_word, w_entryIll};
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
            r_addr  <= r_addr + ADDR_W'(4);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.ready_o       = (r_count != 2'd2);
   assign bus.valid_o       = (r_count != 2'd0);
   assign bus.instruction_o = r_mem[r_rdPtr][32:1];
   assign bus.illegal_o     = r_mem[r_rdPtr][0];
   assign bus.addr_o        = r_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, FIFO backpressure, clear and async reset.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   testCount = 0;
   int   failCount = 0;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   localparam logic BEQ_BAD_ILL = 1'b1;
`else
   localparam logic BEQ_BAD_ILL = 1'b0;
`endif

   instr_encoder_if #(.ADDR_W(32)) bus ();

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkHead(input string tag, input logic [31:0] word, input logic [31:0] addr,
                            input logic ill);
      checkOutput({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
      checkOutput({tag, ".word"}, bus.instruction_o, word);
      checkOutput({tag, ".addr"}, bus.addr_o, addr);
      checkOutput({tag, ".ill"}, 32'(bus.illegal_o), 32'(ill));
   endtask

   task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                                input logic [31:0] imm);
      bus.opcode_i = op;
      bus.rd_i     = rd;
      bus.f3_i     = f3;
      bus.rs1_i    = rs1;
      bus.rs2_i    = rs2;
      bus.f7_i     = f7;
      bus.imm_i    = imm;
      bus.valid_i  = 1'b1;
   endtask

   // Present one field set for one edge, then check the new head.
   task automatic pushThenCheck(input string tag, input logic [4:0] op, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic [31:0] addr, input logic ill);
      applyStimulus(op, rd, f3, rs1, rs2, f7, imm);
      tick();
      bus.valid_i = 1'b0;
      checkHead(tag, word, addr, ill);
   endtask

   task automatic pushOnly(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] imm);
      applyStimulus(op, rd, 3'd0, 5'd0, 5'd0, 7'd0, imm);
      tick();
      bus.valid_i = 1'b0;
   endtask

   initial begin
      bus.clear_i  = 1'b0;
      bus.valid_i  = 1'b0;
      bus.ready_i  = 1'b1;
      bus.opcode_i = '0;
      bus.rd_i     = '0;
      bus.f3_i     = '0;
      bus.rs1_i    = '0;
      bus.rs2_i    = '0;
      bus.f7_i     = '0;
      bus.imm_i    = '0;
      #1 rst = 1'b1;
      tick();
      tick();
      checkOutput("rst.valid", 32'(bus.valid_o), 32'd0);
      checkOutput("rst.ready", 32'(bus.ready_o), 32'd1);
      checkOutput("rst.addr", bus.addr_o, 32'h0);
      checkOutput("rst.word", bus.instruction_o, 32'h0);
      checkOutput("rst.ill", 32'(bus.illegal_o), 32'd0);
      rst = 1'b0;
      tick();

      // Streaming with ready_i high: each push overlaps the pop of the previous word.
      pushThenCheck("addi", 5'b00100, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093, 32'h0, 1'b0);
      pushThenCheck("add", 5'b01100, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3, 32'h4, 1'b0);
      pushThenCheck("sw", 5'b01000, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 32'h0020A423, 32'h8, 1'b0);
      pushThenCheck("beq", 5'b11000, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd16, 32'h00208863, 32'hC, 1'b0);
      tick();
      checkOutput("drain.valid", 32'(bus.valid_o), 32'd0);
      checkOutput("drain.addr", bus.addr_o, 32'h10);

      // Backpressure: two accepts fill the FIFO, third push is held.
      bus.ready_i = 1'b0;
      pushOnly(5'b01101, 5'd5, 32'h12345000);
      checkOutput("bp1.ready", 32'(bus.ready_o), 32'd1);
      pushOnly(5'b11011, 5'd1, 32'h00000800);
      checkOutput("bp2.ready", 32'(bus.ready_o), 32'd0);
      applyStimulus(5'b00100, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
      tick();
      checkOutput("bp3.ready", 32'(bus.ready_o), 32'd0);
      checkHead("bp3.lui", 32'h123452B7, 32'h10, 1'b0);
      bus.ready_i = 1'b1;
      tick();
      checkHead("bp.jal", 32'h001000EF, 32'h14, 1'b0);
      checkOutput("bp.readyBack", 32'(bus.ready_o), 32'd1);
      tick();
      bus.valid_i = 1'b0;
      checkHead("bp.third", 32'hFFF00113, 32'h18, 1'b0);
      tick();
      checkOutput("bp.empty", 32'(bus.valid_o), 32'd0);

      // Unsupported opcode becomes a flagged NOP; the next legal word is clean.
      pushThenCheck("illegal", 5'b11111, 5'd7, 3'd5, 5'd3, 5'd4, 7'h7F, 32'h1234, 32'h00000013, 32'h1C, 1'b1);
      pushThenCheck("legal", 5'b00100, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093, 32'h20, 1'b0);
      pushThenCheck("beqOdd", 5'b11000, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h1001, 32'h80208063, 32'h24, BEQ_BAD_ILL);
      tick();

      // Clear with two pending entries and a pop requested in the same cycle.
      bus.ready_i = 1'b0;
      pushOnly(5'b01101, 5'd5, 32'h12345000);
      pushOnly(5'b11011, 5'd1, 32'h00000800);
      bus.ready_i = 1'b1;
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      checkOutput("clr.valid", 32'(bus.valid_o), 32'd0);
      checkOutput("clr.ready", 32'(bus.ready_o), 32'd1);
      checkOutput("clr.addr", bus.addr_o, 32'h0);
      applyStimulus(5'b00100, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      bus.valid_i = 1'b0;
      checkOutput("clrDrop.valid", 32'(bus.valid_o), 32'd0);
      pushThenCheck("postClr", 5'b01100, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3, 32'h0, 1'b0);

      // Async reset mid-stream, checked between clock edges.
      pushOnly(5'b01101, 5'd5, 32'h12345000);
      bus.ready_i = 1'b0;
      pushOnly(5'b11011, 5'd1, 32'h00000800);
      checkHead("preRst", 32'h123452B7, 32'h4, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst.valid", 32'(bus.valid_o), 32'd0);
      checkOutput("arst.ready", 32'(bus.ready_o), 32'd1);
      checkOutput("arst.addr", bus.addr_o, 32'h0);
      checkOutput("arst.word", bus.instruction_o, 32'h0);
      checkOutput("arst.ill", 32'(bus.illegal_o), 32'd0);
      tick();
      rst = 1'b0;
      bus.ready_i = 1'b1;
      tick();
      pushThenCheck("postRst", 5'b00101, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCDE000, 32'hABCDE217, 32'h0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
